interrupt_arbiter: RTL and testbench
====================================

Name: interrupt_arbiter

Overview:
- Collects NUM_IRQ external interrupt lines and latches rising edges into a pending register.
- Applies a per-line mask and a global enable, then selects one line by fixed priority (lowest index wins).
- Issues a single interrupt request pulse to the core's interrupt control unit, together with the chosen ISR vector.
- Blocks further requests until the core signals return-from-ISR. Sits between the peripherals and the interrupt control unit in the RV32IM pipeline.

Parameters:
- NUM_IRQ, 8, number of interrupt request lines (1..32).
- VEC_BASE, 500, ISR address for line 0.
- VEC_STRIDE, 16, address spacing between consecutive line vectors.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low; 0 forces reset immediately.
- irq_in  in  NUM_IRQ  raw interrupt lines, synchronous to clk; rising edge = event.
- global_en  in  1  1 = arbitration allowed.
- mask_we  in  1  write strobe for mask register.
- mask_wdata  in  NUM_IRQ  new mask; bit=1 enables the line.
- pend_clr  in  NUM_IRQ  software clear of pending bits (one-cycle strobe per bit).
- return_from_isr  in  1  core has executed ISR return.
- interupt_signal  out  1  one-cycle request pulse to the interrupt control unit.
- isr_vector  out  32  vector of the granted line; stable from the pulse until return.
- irq_id  out  5  index of the granted line.
- in_service  out  1  1 from grant until return accepted.
- pending  out  NUM_IRQ  pending register readback.
- mask  out  NUM_IRQ  mask register readback.

Behaviour:
- Reset values:
  - state = IDLE.
  - pending = 0, irq_prev = 0, mask = all ones.
  - interupt_signal = 0, in_service = 0, irq_id = 0, isr_vector = VEC_BASE.
- Edge detect:
  - irq_prev registers irq_in each cycle.
  - A bit is an edge when irq_in & ~irq_prev.
  - An edge sets the pending bit at the next posedge, so latency from edge to pending is 1 cycle.
- Pending update priority, per bit per cycle:
  - An edge set wins over both the grant clear and pend_clr in the same cycle.
  - Otherwise the grant clear or pend_clr clears the bit.
  - Otherwise the bit holds.
- Mask:
  - mask_we loads mask_wdata at posedge.
  - The mask affects eligibility only; masked lines still become pending.
- Eligible vector = pending & mask, qualified by global_en.
- States:
  - IDLE: if the eligible vector is nonzero, grant the lowest set index k. Latch irq_id = k and isr_vector = VEC_BASE + k*VEC_STRIDE (32-bit, modulo 2^32). Clear pending[k]. Go to REQUEST. Otherwise stay in IDLE.
  - REQUEST: interupt_signal = 1 for exactly this cycle; in_service = 1. Go to IN_SERVICE unconditionally.
  - IN_SERVICE: in_service = 1; no arbitration. On return_from_isr = 1, go to IDLE and drop in_service at that edge.
- Latency:
  - Edge to pending: 1 cycle.
  - Pending to grant (IDLE): 1 cycle.
  - Grant to interupt_signal: the next cycle, so 3 posedges from edge to pulse.
  - Back-to-back: after return, the earliest next pulse is 2 cycles later (IDLE, then REQUEST).
- Boundary conditions:
  - return_from_isr in IDLE or REQUEST is ignored.
  - Clearing global_en or the mask while in REQUEST or IN_SERVICE does not abort the current service.
  - An edge on the line currently in service re-pends it and is serviced after return.
  - Multiple simultaneous edges are all latched and serviced in index order, one per ISR.
  - Asserting reset (low) in any state returns to IDLE immediately, discards pending, and deasserts interupt_signal asynchronously.
  - irq_in held high produces no new event until it falls and rises again.

Decomposition:
- Package irq_pkg holds:
  - state encoding constants IDLE = 0, REQUEST = 1, IN_SERVICE = 2;
  - defaults for VEC_BASE and VEC_STRIDE;
  - the 5-bit id width.
- One sub-module, irq_priority_encoder: combinational, takes an NUM_IRQ request vector and outputs a valid bit plus the lowest set index. It is instantiated once in IDLE arbitration.

Test Plan:
- Reset, then pulse irq_in[3] → pending = 0x08 after 1 cycle; interupt_signal high for one cycle 3 posedges after the edge; isr_vector = 548; irq_id = 3; pending = 0x00.
- Edges on lines 5 and 2 in the same cycle → line 2 served first (vector 532); after return_from_isr, line 5 served (vector 580) exactly 2 cycles later.
- mask = 0xFB, then pulse line 2 → no request and pending = 0x04; write mask = 0xFF → request for line 2 follows.
- During IN_SERVICE of line 1, pulse line 0 and line 1 → no pulse until return; then line 0 (vector 500), then line 1 (vector 516).
- Drive reset low in REQUEST → interupt_signal drops immediately; in_service = 0, pending = 0, mask = 0xFF; no pulse after release.
- global_en = 0 with pending = 0x10 → no request; pend_clr = 0x10 → pending = 0; raise global_en → still no request.

Source files
------------

// File: rtl/interrupt_arbiter_pkg.sv
// Shared types and defaults for the interrupt arbiter: state encoding,
// vector defaults and the grant payload carried from arbitration to the outputs.
package irq_pkg;

  localparam int unsigned ID_W           = 5;
  localparam int unsigned VEC_W          = 32;
  localparam int unsigned VEC_BASE_DEF   = 500;
  localparam int unsigned VEC_STRIDE_DEF = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQUEST    = 2'd1,
    IN_SERVICE = 2'd2
  } state_e;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [VEC_W-1:0] vector;
  } grant_t;

endpackage

// File: rtl/interrupt_arbiter_if.sv
// Bus between peripherals/core (master side) and the interrupt arbiter (slave side).
interface interrupt_arbiter_if
  import irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
);

  logic [NUM_IRQ-1:0] irq_in;
  logic               global_en;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic [NUM_IRQ-1:0] pend_clr;
  logic               return_from_isr;
  logic               interupt_signal;
  logic [VEC_W-1:0]   isr_vector;
  logic [ID_W-1:0]    irq_id;
  logic               in_service;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;

  modport master (
    output irq_in, global_en, mask_we, mask_wdata, pend_clr, return_from_isr,
    input  interupt_signal, isr_vector, irq_id, in_service, pending, mask
  );

  modport slave (
    input  irq_in, global_en, mask_we, mask_wdata, pend_clr, return_from_isr,
    output interupt_signal, isr_vector, irq_id, in_service, pending, mask
  );

endinterface

// File: rtl/irq_priority_encoder.sv
// Combinational fixed-priority encoder: lowest set request index wins.
module irq_priority_encoder
  import irq_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] idx
);

  // Scan from the top so the lowest set index is written last.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_arbiter.sv
// Latches interrupt edges, arbitrates by fixed priority and issues one request
// pulse with its ISR vector, holding off further requests until ISR return.
module interrupt_arbiter
  import irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = 8,
  parameter int unsigned VEC_BASE   = VEC_BASE_DEF,
  parameter int unsigned VEC_STRIDE = VEC_STRIDE_DEF
) (
  input logic                clk,
  input logic                reset,
  interrupt_arbiter_if.slave bus
);

  state_e             state, state_next;
  logic [NUM_IRQ-1:0] irq_prev, pending_q, mask_q;
  logic [NUM_IRQ-1:0] eligible_c, edge_c, grant_clr_c;
  logic               pulse_q, in_service_q;
  logic               pe_valid_c, grant_c;
  logic [ID_W-1:0]    pe_idx_c;
  grant_t             grant_q, grant_new_c;

  assign edge_c     = bus.irq_in & ~irq_prev;
  assign eligible_c = bus.global_en ? (pending_q & mask_q) : '0;

  irq_priority_encoder #(.N(NUM_IRQ)) u_prio (
    .req   (eligible_c),
    .valid (pe_valid_c),
    .idx   (pe_idx_c)
  );

  assign grant_new_c.id     = pe_idx_c;
  assign grant_new_c.vector = VEC_W'(VEC_BASE) + VEC_W'(pe_idx_c) * VEC_W'(VEC_STRIDE);
  assign grant_clr_c        = grant_c ? (NUM_IRQ'(1) << pe_idx_c) : '0;

  // Next-state: arbitration happens only in IDLE; return is honoured only in IN_SERVICE.
  always_comb begin
    state_next = state;
    grant_c    = 1'b0;
    case (state)
      IDLE: begin
        if (pe_valid_c) begin
          grant_c    = 1'b1;
          state_next = REQUEST;
        end
      end
      REQUEST:    state_next = IN_SERVICE;
      IN_SERVICE: if (bus.return_from_isr) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Edge set beats both the grant clear and software clear on the same bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      irq_prev       <= '0;
      pending_q      <= '0;
      mask_q         <= '1;
      pulse_q        <= 1'b0;
      in_service_q   <= 1'b0;
      grant_q.id     <= '0;
      grant_q.vector <= VEC_W'(VEC_BASE);
    end else begin
      state        <= state_next;
      irq_prev     <= bus.irq_in;
      pending_q    <= (pending_q & ~(grant_clr_c | bus.pend_clr)) | edge_c;
      pulse_q      <= (state == REQUEST);
      in_service_q <= (state_next != IDLE);
      if (bus.mask_we) mask_q  <= bus.mask_wdata;
      if (grant_c)     grant_q <= grant_new_c;
    end
  end

  assign bus.interupt_signal = pulse_q;
  assign bus.in_service      = in_service_q;
  assign bus.isr_vector      = grant_q.vector;
  assign bus.irq_id          = grant_q.id;
  assign bus.pending         = pending_q;
  assign bus.mask            = mask_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Scenario tasks plus a randomized run against a cycle-level behavioural model.
module tb_interrupt_arbiter;
  import irq_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned VB = 500;
  localparam int unsigned VS = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  interrupt_arbiter_if #(.NUM_IRQ(N)) bus ();

  interrupt_arbiter #(.NUM_IRQ(N), .VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: busy = an ISR is outstanding, fresh = grant just made.
  logic [N-1:0] m_pend, m_prev, m_mask;
  bit           m_busy, m_fresh, m_pulse;
  int           m_id;
  logic [31:0]  m_vec;

  task automatic model_reset();
    m_pend = '0; m_prev = '0; m_mask = '1;
    m_busy = 0; m_fresh = 0; m_pulse = 0;
    m_id = 0; m_vec = 32'(VB);
  endtask

  task automatic model_step();
    logic [N-1:0] elig, clr;
    int k;
    bit accept;
    elig = bus.global_en ? (m_pend & m_mask) : '0;
    k = -1;
    if (!m_busy)
      for (int i = 0; i < int'(N); i++) if (elig[i] && k < 0) k = i;
    accept = m_busy && !m_fresh && bus.return_from_isr;
    clr = bus.pend_clr;
    if (k >= 0) clr[k] = 1'b1;
    m_pend  = (m_pend & ~clr) | (bus.irq_in & ~m_prev);
    m_prev  = bus.irq_in;
    if (bus.mask_we) m_mask = bus.mask_wdata;
    m_pulse = m_fresh;
    if (k >= 0) begin
      m_id  = k;
      m_vec = 32'(VB) + 32'(k) * 32'(VS);
    end
    m_fresh = (k >= 0);
    if (k >= 0) m_busy = 1;
    else if (accept) m_busy = 0;
  endtask

  task automatic drive_idle();
    bus.irq_in = '0; bus.global_en = 1'b1; bus.mask_we = 1'b0;
    bus.mask_wdata = '0; bus.pend_clr = '0; bus.return_from_isr = 1'b0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_pulse(input int max_cycles, output int n);
    n = 0;
    while (!bus.interupt_signal && n < max_cycles) begin
      cycle();
      n++;
    end
  endtask

  task automatic count_pulses(input int ncyc, output int p);
    p = 0;
    for (int i = 0; i < ncyc; i++) begin
      cycle();
      if (bus.interupt_signal) p++;
    end
  endtask

  task automatic isr_return();
    bus.return_from_isr = 1'b1;
    cycle();
    bus.return_from_isr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.interupt_signal, bus.in_service, bus.pending, bus.mask, bus.irq_id, bus.isr_vector}
        !== {1'b0, 1'b0, 8'h00, 8'hFF, 5'd0, 32'd500}) begin
      failures++;
      $display("FAIL reset_values got pulse=%0b insvc=%0b pend=%h mask=%h id=%0d vec=%0d",
               bus.interupt_signal, bus.in_service, bus.pending, bus.mask, bus.irq_id, bus.isr_vector);
    end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    bus.irq_in = 8'h08;
    cycle();
    checks++;
    if (bus.pending !== 8'h08) begin
      failures++; $display("FAIL single_pend got %h want 08", bus.pending);
    end
    bus.irq_in = '0;
    cycle();
    wait_pulse(5, n);
    checks++;
    if (!(bus.interupt_signal === 1'b1 && n == 1)) begin
      failures++; $display("FAIL single_latency got pulse=%0b after %0d more cycles want 1 after 1", bus.interupt_signal, n);
    end
    checks++;
    if ({bus.isr_vector, bus.irq_id, bus.pending, bus.in_service} !== {32'd548, 5'd3, 8'h00, 1'b1}) begin
      failures++; $display("FAIL single_grant got vec=%0d id=%0d pend=%h insvc=%0b want 548 3 00 1",
                           bus.isr_vector, bus.irq_id, bus.pending, bus.in_service);
    end
    cycle();
    checks++;
    if (bus.interupt_signal !== 1'b0) begin
      failures++; $display("FAIL single_one_cycle got pulse=%0b want 0", bus.interupt_signal);
    end
    bus.return_from_isr = 1'b1;
    cycle();
    bus.return_from_isr = 1'b0;
    checks++;
    if (bus.in_service !== 1'b0) begin
      failures++; $display("FAIL single_return got insvc=%0b want 0", bus.in_service);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    bus.irq_in = 8'h24;
    cycle();
    bus.irq_in = '0;
    wait_pulse(8, n);
    checks++;
    if ({bus.interupt_signal, bus.isr_vector, bus.irq_id} !== {1'b1, 32'd532, 5'd2}) begin
      failures++; $display("FAIL b2b_first got pulse=%0b vec=%0d id=%0d want 1 532 2",
                           bus.interupt_signal, bus.isr_vector, bus.irq_id);
    end
    cycle();
    isr_return();
    wait_pulse(8, n);
    checks++;
    if ({bus.interupt_signal, bus.isr_vector, bus.irq_id} !== {1'b1, 32'd580, 5'd5} || n != 2) begin
      failures++; $display("FAIL b2b_second got pulse=%0b vec=%0d id=%0d gap=%0d want 1 580 5 gap 2",
                           bus.interupt_signal, bus.isr_vector, bus.irq_id, n);
    end
    isr_return();
  endtask

  task automatic test_mask();
    int p, n;
    do_reset();
    bus.mask_we = 1'b1; bus.mask_wdata = 8'hFB;
    cycle();
    bus.mask_we = 1'b0;
    bus.irq_in = 8'h04;
    cycle();
    bus.irq_in = '0;
    count_pulses(6, p);
    checks++;
    if (p != 0 || bus.pending !== 8'h04 || bus.mask !== 8'hFB) begin
      failures++; $display("FAIL mask_block got pulses=%0d pend=%h mask=%h want 0 04 FB", p, bus.pending, bus.mask);
    end
    bus.mask_we = 1'b1; bus.mask_wdata = 8'hFF;
    cycle();
    bus.mask_we = 1'b0;
    wait_pulse(6, n);
    checks++;
    if ({bus.interupt_signal, bus.irq_id, bus.pending} !== {1'b1, 5'd2, 8'h00}) begin
      failures++; $display("FAIL mask_release got pulse=%0b id=%0d pend=%h want 1 2 00",
                           bus.interupt_signal, bus.irq_id, bus.pending);
    end
    cycle();
    isr_return();
  endtask

  task automatic test_repend();
    int p, n;
    do_reset();
    bus.irq_in = 8'h02;
    cycle();
    bus.irq_in = '0;
    wait_pulse(6, n);
    cycle();
    bus.irq_in = 8'h03;
    bus.global_en = 1'b0;
    cycle();
    bus.irq_in = '0;
    count_pulses(5, p);
    checks++;
    if (p != 0 || bus.pending !== 8'h03 || bus.in_service !== 1'b1 || bus.irq_id !== 5'd1) begin
      failures++; $display("FAIL repend_hold got pulses=%0d pend=%h insvc=%0b id=%0d want 0 03 1 1",
                           p, bus.pending, bus.in_service, bus.irq_id);
    end
    bus.global_en = 1'b1;
    isr_return();
    wait_pulse(6, n);
    checks++;
    if ({bus.interupt_signal, bus.isr_vector} !== {1'b1, 32'd500}) begin
      failures++; $display("FAIL repend_line0 got pulse=%0b vec=%0d want 1 500", bus.interupt_signal, bus.isr_vector);
    end
    cycle();
    isr_return();
    wait_pulse(6, n);
    checks++;
    if ({bus.interupt_signal, bus.isr_vector} !== {1'b1, 32'd516}) begin
      failures++; $display("FAIL repend_line1 got pulse=%0b vec=%0d want 1 516", bus.interupt_signal, bus.isr_vector);
    end
    cycle();
    isr_return();
  endtask

  task automatic test_async_reset();
    int p, n;
    do_reset();
    bus.mask_we = 1'b1; bus.mask_wdata = 8'h7F;
    cycle();
    bus.mask_we = 1'b0;
    bus.irq_in = 8'h21;
    cycle();
    bus.irq_in = '0;
    wait_pulse(6, n);
    checks++;
    if (bus.interupt_signal !== 1'b1 || bus.pending !== 8'h20) begin
      failures++; $display("FAIL areset_pre got pulse=%0b pend=%h want 1 20", bus.interupt_signal, bus.pending);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.interupt_signal, bus.in_service, bus.pending, bus.mask} !== {1'b0, 1'b0, 8'h00, 8'hFF}) begin
      failures++; $display("FAIL areset_now got pulse=%0b insvc=%0b pend=%h mask=%h want 0 0 00 FF",
                           bus.interupt_signal, bus.in_service, bus.pending, bus.mask);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    count_pulses(6, p);
    checks++;
    if (p != 0 || bus.in_service !== 1'b0) begin
      failures++; $display("FAIL areset_after got pulses=%0d insvc=%0b want 0 0", p, bus.in_service);
    end
  endtask

  task automatic test_global_en();
    int p;
    do_reset();
    bus.global_en = 1'b0;
    bus.irq_in = 8'h10;
    cycle();
    bus.irq_in = '0;
    count_pulses(4, p);
    checks++;
    if (p != 0 || bus.pending !== 8'h10) begin
      failures++; $display("FAIL gen_block got pulses=%0d pend=%h want 0 10", p, bus.pending);
    end
    bus.pend_clr = 8'h10;
    cycle();
    bus.pend_clr = '0;
    checks++;
    if (bus.pending !== 8'h00) begin
      failures++; $display("FAIL gen_clear got pend=%h want 00", bus.pending);
    end
    bus.global_en = 1'b1;
    count_pulses(4, p);
    checks++;
    if (p != 0) begin
      failures++; $display("FAIL gen_enable got pulses=%0d want 0", p);
    end
  endtask

  task automatic test_held_high();
    int p, n;
    do_reset();
    bus.irq_in = 8'h80;
    count_pulses(10, p);
    checks++;
    if (p != 1) begin
      failures++; $display("FAIL held_single got pulses=%0d want 1", p);
    end
    isr_return();
    count_pulses(8, p);
    checks++;
    if (p != 0 || bus.pending !== 8'h00) begin
      failures++; $display("FAIL held_noretrig got pulses=%0d pend=%h want 0 00", p, bus.pending);
    end
    bus.irq_in = '0;
    cycle();
    bus.irq_in = 8'h80;
    wait_pulse(6, n);
    checks++;
    if ({bus.interupt_signal, bus.irq_id, bus.isr_vector} !== {1'b1, 5'd7, 32'd612}) begin
      failures++; $display("FAIL held_rerise got pulse=%0b id=%0d vec=%0d want 1 7 612",
                           bus.interupt_signal, bus.irq_id, bus.isr_vector);
    end
    bus.irq_in = '0;
    cycle();
    isr_return();
  endtask

  task automatic test_random();
    logic [N+N+N+2+ID_W+31:0] got, exp;
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 3000 && bad < 20; c++) begin
      bus.irq_in          = bus.irq_in ^ (N'($urandom) & N'($urandom) & N'($urandom));
      bus.global_en       = ($urandom_range(0, 9) != 0);
      bus.mask_we         = ($urandom_range(0, 19) == 0);
      bus.mask_wdata      = N'($urandom);
      bus.pend_clr        = ($urandom_range(0, 9) == 0) ? (N'($urandom) & N'($urandom)) : '0;
      bus.return_from_isr = ($urandom_range(0, 3) == 0);
      cycle();
      got = {bus.interupt_signal, bus.in_service, bus.pending, bus.mask, bus.pending ^ bus.mask,
             bus.irq_id, bus.isr_vector};
      exp = {m_pulse, m_busy, m_pend, m_mask, m_pend ^ m_mask, 5'(m_id), m_vec};
      checks++;
      if (got !== exp) begin
        failures++; bad++;
        $display("FAIL random_cycle%0d got pulse=%0b insvc=%0b pend=%h mask=%h id=%0d vec=%0d want %0b %0b %h %h %0d %0d",
                 c, bus.interupt_signal, bus.in_service, bus.pending, bus.mask, bus.irq_id, bus.isr_vector,
                 m_pulse, m_busy, m_pend, m_mask, m_id, m_vec);
      end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_mask();
    test_repend();
    test_async_reset();
    test_global_en();
    test_held_high();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
